// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end feeding the CPU core.
// Issues sequential word fetches to instruction memory over a req/ack handshake,
// buffers the returned words with their PCs in a small FIFO, and presents one
// {pc, instr} pair per cycle to the core over valid/ready. A redirect flushes
// the FIFO and discards any in-flight fetch.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   redirect          one-cycle flush pulse; redirect_pc gives the new fetch address
//   mem_req/mem_addr  fetch request to imem; held with a stable address until mem_ack
//   mem_ack/mem_rdata imem response, one cycle, only while mem_req is high
//   out_valid/ready   head-of-queue handshake to the core
//   out_pc/out_instr  head entry contents
//   q_count           current FIFO occupancy
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            has_space;
  logic            push;
  logic            pop;
  logic [31:0]     redirect_aligned;

  assign has_space        = (count_q < Full);
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // A redirect cycle ignores any pop; the FIFO is cleared instead.
  assign pop = out_valid && out_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    mem_req    = 1'b0;
    mem_addr   = req_addr_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_addr = fetch_pc_q;
        // Request only with guaranteed room, so the acked push can never overflow.
        if (!redirect && has_space) begin
          mem_req    = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = StIdle;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Stale fetch still owed by imem; keep the handshake alive and drop the data.
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_aligned;
    end

    // The idle-state request is combinational, so hold it low while reset is asserted.
    if (!rst) begin
      mem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign q_count   = count_q;

endmodule
